vector_fetch: RTL and testbench

VECTOR_FETCH -- requirements
Module: vector_fetch

---
 rtl/vector_fetch.sv | 218 +++++++++++++++++++++
 tb/tb_vector_fetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_fetch.sv
// vector_fetch: reads 128-bit vectors as four consecutive 32-bit words from a dual-port BRAM
// (two words per cycle over ports A and B) and presents them on a valid/ready interface.
//
// Optional feature: define VECTOR_FETCH_CHECKSUM_EN to build the running XOR checksum.
// Without it CHECKSUM is tied to 0 and the port list stays the same.
//
// Ports:
//   CLK, RST_N               clock, asynchronous active-low reset
//   START, ABORT             begin a run (sampled only in IDLE), terminate a run in progress
//   BASE_ADDR, NUM_VEC       first word address, number of 128-bit vectors to fetch
//   BRAM_EN_A/B, BRAM_ADDR_A/B  registered read enables and addresses
//   BRAM_DOUT_A/B            BRAM read data, one-cycle latency. Only bits [31:0] are used,
//                            so RAM_WIDTH must be at least 32.
//   VEC_DATA, VEC_VALID, VEC_READY  assembled vector and handshake; word +0 sits in [31:0]
//   VEC_INDEX                ordinal of the presented vector, starting at 0
//   BUSY, DONE               run in progress, one-cycle completion pulse
//   CHECKSUM                 XOR of all words accepted in the current run
//
// The BRAM write enables are not driven here. Tie WE_A and WE_B of the connected ports to 0.
module vector_fetch #(
  parameter int unsigned RAM_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_BITS = 13
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     START,
  input  logic                     ABORT,
  input  logic [RAM_ADDR_BITS-1:0] BASE_ADDR,
  input  logic [10:0]              NUM_VEC,
  output logic                     BRAM_EN_A,
  output logic                     BRAM_EN_B,
  output logic [RAM_ADDR_BITS-1:0] BRAM_ADDR_A,
  output logic [RAM_ADDR_BITS-1:0] BRAM_ADDR_B,
  input  logic [RAM_WIDTH-1:0]     BRAM_DOUT_A,
  input  logic [RAM_WIDTH-1:0]     BRAM_DOUT_B,
  output logic [127:0]             VEC_DATA,
  output logic                     VEC_VALID,
  input  logic                     VEC_READY,
  output logic [10:0]              VEC_INDEX,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [31:0]              CHECKSUM
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRdLo    = 3'd1,
    StRdHi    = 3'd2,
    StCapHi   = 3'd3,
    StPresent = 3'd4,
    StFinish  = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [10:0]              cnt_q, cnt_d;
  logic                     en_q, en_d;
  logic [RAM_ADDR_BITS-1:0] addr_a_q, addr_a_d;
  logic [RAM_ADDR_BITS-1:0] addr_b_q, addr_b_d;
  logic [127:0]             data_q, data_d;
  logic                     valid_q, valid_d;
  logic [10:0]              index_q, index_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic start_acc;
  logic hs;

  assign start_acc = (state_q == StIdle) && START;
  // Abort wins over an accepting handshake in the same cycle.
  assign hs = (state_q == StPresent) && valid_q && VEC_READY && !ABORT;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    en_d     = 1'b0;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    data_d   = data_q;
    valid_d  = valid_q;
    index_d  = index_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (ABORT && (state_q != StIdle)) begin
      state_d = StIdle;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_acc) begin
            ptr_d   = BASE_ADDR;
            cnt_d   = NUM_VEC;
            index_d = '0;
            busy_d  = 1'b1;
            if (NUM_VEC == 11'd0) begin
              state_d = StFinish;
            end else begin
              // Outputs are registered, so the low-pair read is issued on this edge.
              state_d  = StRdLo;
              en_d     = 1'b1;
              addr_a_d = BASE_ADDR;
              addr_b_d = BASE_ADDR + RAM_ADDR_BITS'(1);
            end
          end
        end
        StRdLo: begin
          state_d  = StRdHi;
          en_d     = 1'b1;
          addr_a_d = ptr_q + RAM_ADDR_BITS'(2);
          addr_b_d = ptr_q + RAM_ADDR_BITS'(3);
        end
        StRdHi: begin
          // Data for P, P+1 arrives one cycle after the RD_LO read.
          data_d[63:0] = {BRAM_DOUT_B[31:0], BRAM_DOUT_A[31:0]};
          state_d      = StCapHi;
        end
        StCapHi: begin
          data_d[127:64] = {BRAM_DOUT_B[31:0], BRAM_DOUT_A[31:0]};
          valid_d        = 1'b1;
          state_d        = StPresent;
        end
        StPresent: begin
          if (hs) begin
            valid_d = 1'b0;
            ptr_d   = ptr_q + RAM_ADDR_BITS'(4);
            index_d = index_q + 11'd1;
            cnt_d   = cnt_q - 11'd1;
            if (cnt_q != 11'd1) begin
              state_d  = StRdLo;
              en_d     = 1'b1;
              addr_a_d = ptr_q + RAM_ADDR_BITS'(4);
              addr_b_d = ptr_q + RAM_ADDR_BITS'(5);
            end else begin
              state_d = StFinish;
            end
          end
        end
        StFinish: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      index_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      index_q  <= index_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BRAM_EN_A   = en_q;
  assign BRAM_EN_B   = en_q;
  assign BRAM_ADDR_A = addr_a_q;
  assign BRAM_ADDR_B = addr_b_q;
  assign VEC_DATA    = data_q;
  assign VEC_VALID   = valid_q;
  assign VEC_INDEX   = index_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;

`ifdef VECTOR_FETCH_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_acc) begin
      csum_d = '0;
    end else if (hs) begin
      csum_d = csum_q ^ data_q[31:0] ^ data_q[63:32] ^ data_q[95:64] ^ data_q[127:96];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign CHECKSUM = csum_q;
`else
  assign CHECKSUM = 32'h0;
`endif

endmodule

// File: tb/tb_vector_fetch.sv
`timescale 1ns/1ps
module tb_vector_fetch;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;

`ifdef VECTOR_FETCH_CHECKSUM_EN
  localparam logic [31:0] ExpCsumT1 = 32'h4444_4444;
`else
  localparam logic [31:0] ExpCsumT1 = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [AW-1:0] base_addr;
  logic [10:0]   num_vec;
  logic          en_a, en_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] dout_a, dout_b;
  logic [127:0]  vec_data;
  logic          vec_valid, vec_ready;
  logic [10:0]   vec_index;
  logic          busy, done;
  logic [31:0]   checksum;

  logic [31:0] mem [0:8191];

  int checks = 0;
  int errors = 0;

  logic [127:0]      exp_data_q[$];
  logic [10:0]       exp_idx_q[$];
  logic [2*AW-1:0]   exp_addr_q[$];

  always #5 clk = ~clk;

  vector_fetch #(
    .RAM_WIDTH     (DW),
    .RAM_ADDR_BITS (AW)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .START       (start),
    .ABORT       (abort),
    .BASE_ADDR   (base_addr),
    .NUM_VEC     (num_vec),
    .BRAM_EN_A   (en_a),
    .BRAM_EN_B   (en_b),
    .BRAM_ADDR_A (addr_a),
    .BRAM_ADDR_B (addr_b),
    .BRAM_DOUT_A (dout_a),
    .BRAM_DOUT_B (dout_b),
    .VEC_DATA    (vec_data),
    .VEC_VALID   (vec_valid),
    .VEC_READY   (vec_ready),
    .VEC_INDEX   (vec_index),
    .BUSY        (busy),
    .DONE        (done),
    .CHECKSUM    (checksum)
  );

  // BRAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (en_a) dout_a <= mem[addr_a];
    if (en_b) dout_b <= mem[addr_b];
  end

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: accepted vectors and issued reads are compared against queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vec_valid && vec_ready) begin
        if (exp_data_q.size() == 0) begin
          check("sb_unexpected_vec", 128'(vec_index), 128'h0 - 1);
        end else begin
          check("sb_vec_data", vec_data, exp_data_q.pop_front());
          check("sb_vec_index", 128'(vec_index), 128'(exp_idx_q.pop_front()));
        end
      end
      if (en_a || en_b) begin
        check("sb_en_pair", 128'(en_b), 128'(en_a));
        if (exp_addr_q.size() == 0) begin
          check("sb_unexpected_read", 128'({addr_a, addr_b}), 128'h0 - 1);
        end else begin
          check("sb_read_addr", 128'({addr_a, addr_b}), 128'(exp_addr_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic push_vec(input logic [127:0] d, input logic [10:0] idx);
    exp_data_q.push_back(d);
    exp_idx_q.push_back(idx);
  endtask

  task automatic push_rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    exp_addr_q.push_back({a, b});
  endtask

  // Returns at the negedge after the edge that samples START.
  task automatic start_run(input logic [AW-1:0] base, input logic [10:0] n);
    @(negedge clk);
    base_addr = base;
    num_vec   = n;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!vec_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid_seen"}, 128'(vec_valid), 128'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 128'(done), 128'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_en_a"}, 128'(en_a), 128'd0);
    check({name, "_en_b"}, 128'(en_b), 128'd0);
    check({name, "_addr_a"}, 128'(addr_a), 128'd0);
    check({name, "_addr_b"}, 128'(addr_b), 128'd0);
    check({name, "_data"}, vec_data, 128'd0);
    check({name, "_valid"}, 128'(vec_valid), 128'd0);
    check({name, "_index"}, 128'(vec_index), 128'd0);
    check({name, "_busy"}, 128'(busy), 128'd0);
    check({name, "_done"}, 128'(done), 128'd0);
    check({name, "_csum"}, 128'(checksum), 128'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    num_vec   = '0;
    vec_ready = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[16] = 32'h1111_1111;
    mem[17] = 32'h2222_2222;
    mem[18] = 32'h3333_3333;
    mem[19] = 32'h4444_4444;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single vector: latency, data, DONE timing, checksum.
    push_rd(13'd16, 13'd17);
    push_rd(13'd18, 13'd19);
    push_vec(128'h44444444_33333333_22222222_11111111, 11'd0);
    start_run(13'd16, 11'd1);
    check("t1_valid_c0", 128'(vec_valid), 128'd0);
    check("t1_busy", 128'(busy), 128'd1);
    @(negedge clk);
    check("t1_valid_c1", 128'(vec_valid), 128'd0);
    @(negedge clk);
    check("t1_valid_c2", 128'(vec_valid), 128'd0);
    @(negedge clk);
    check("t1_valid_c3", 128'(vec_valid), 128'd1);
    check("t1_data", vec_data, 128'h44444444_33333333_22222222_11111111);
    @(negedge clk);
    check("t1_valid_drop", 128'(vec_valid), 128'd0);
    check("t1_done_early", 128'(done), 128'd0);
    @(negedge clk);
    check("t1_done", 128'(done), 128'd1);
    check("t1_busy_clr", 128'(busy), 128'd0);
    check("t1_csum", 128'(checksum), 128'(ExpCsumT1));
    @(negedge clk);
    check("t1_done_pulse", 128'(done), 128'd0);

    // Backpressure on vector 1, with an ignored START during the stall.
    for (int v = 0; v < 3; v++) begin
      push_rd(13'(100 + 4 * v), 13'(101 + 4 * v));
      push_rd(13'(102 + 4 * v), 13'(103 + 4 * v));
    end
    push_vec(128'hC0DE0067_C0DE0066_C0DE0065_C0DE0064, 11'd0);
    push_vec(128'hC0DE006B_C0DE006A_C0DE0069_C0DE0068, 11'd1);
    push_vec(128'hC0DE006F_C0DE006E_C0DE006D_C0DE006C, 11'd2);
    start_run(13'd100, 11'd3);
    wait_valid("t2_v0");
    @(negedge clk);
    vec_ready = 1'b0;
    wait_valid("t2_v1");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_stall_data", vec_data, 128'hC0DE006B_C0DE006A_C0DE0069_C0DE0068);
      check("t2_stall_index", 128'(vec_index), 128'd1);
      check("t2_stall_valid", 128'(vec_valid), 128'd1);
      check("t2_stall_no_en", 128'({en_a, en_b}), 128'd0);
      if (i == 1) begin
        base_addr = 13'd0;
        num_vec   = 11'd5;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    vec_ready = 1'b1;
    wait_done("t2");
    @(negedge clk);

    // Address wrap across the top of the BRAM.
    push_rd(13'd8188, 13'd8189);
    push_rd(13'd8190, 13'd8191);
    push_rd(13'd0, 13'd1);
    push_rd(13'd2, 13'd3);
    push_vec(128'hC0DE1FFF_C0DE1FFE_C0DE1FFD_C0DE1FFC, 11'd0);
    push_vec(128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000, 11'd1);
    start_run(13'd8188, 11'd2);
    wait_done("t3");
    @(negedge clk);

    // Zero-length run: DONE one cycle after START, no reads.
    start_run(13'd50, 11'd0);
    check("t4_done_c0", 128'(done), 128'd0);
    check("t4_busy_c0", 128'(busy), 128'd1);
    check("t4_no_en_c0", 128'({en_a, en_b}), 128'd0);
    @(negedge clk);
    check("t4_done_c1", 128'(done), 128'd1);
    check("t4_busy_c1", 128'(busy), 128'd0);
    check("t4_csum", 128'(checksum), 128'd0);
    @(negedge clk);

    // Abort while in RD_HI.
    push_rd(13'd40, 13'd41);
    push_rd(13'd42, 13'd43);
    start_run(13'd40, 11'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_busy", 128'(busy), 128'd0);
    check("t5_valid", 128'(vec_valid), 128'd0);
    check("t5_no_en", 128'({en_a, en_b}), 128'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_done", 128'(done), 128'd0);
      check("t5_no_valid", 128'(vec_valid), 128'd0);
    end

    // Reset while presenting.
    vec_ready = 1'b0;
    push_rd(13'd16, 13'd17);
    push_rd(13'd18, 13'd19);
    start_run(13'd16, 11'd1);
    wait_valid("t6");
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(negedge clk);
    rst_n     = 1'b1;
    vec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_idle_busy", 128'(busy), 128'd0);
      check("t6_idle_done", 128'(done), 128'd0);
    end

    // A fresh START after reset runs normally.
    push_rd(13'd16, 13'd17);
    push_rd(13'd18, 13'd19);
    push_vec(128'h44444444_33333333_22222222_11111111, 11'd0);
    start_run(13'd16, 11'd1);
    wait_done("t7");
    check("t7_csum", 128'(checksum), 128'(ExpCsumT1));
    @(negedge clk);

    check("end_vec_queue", 128'(exp_data_q.size()), 128'd0);
    check("end_addr_queue", 128'(exp_addr_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
